// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART 8n1 TX controller over a valid/ready/data handshake.
// Optional LF -> CR LF expansion on the drain side is enabled by defining UART_TXQ_CRLF_EN.
module uart_tx_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_data_i,
    output logic             wr_ready_o,
    input  logic             flush_i,
    input  logic             ovf_clr_i,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic [7:0]       tx_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          drop;
    logic          handshake;
    logic          pop;
    logic          hold_lf;
    logic [7:0]    head;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign handshake = tx_valid_o && tx_ready_i;

    // Flush outranks both sides: a push in the flush cycle is neither stored nor counted as dropped.
    assign push = wr_en_i && !full && !flush_i;
    assign drop = wr_en_i && full && !flush_i;
    assign pop  = handshake && !hold_lf;

`ifdef UART_TXQ_CRLF_EN
    localparam logic [0:0] StPass   = 1'b0;
    localparam logic [0:0] StCrSent = 1'b1;

    logic [0:0] st_q, st_d;

    // In StPass a head LF is presented as CR first and stays in the FIFO.
    assign hold_lf   = (st_q == StPass) && (head == 8'h0A);
    assign tx_data_o = hold_lf ? 8'h0D : head;

    always_comb begin
        st_d = st_q;
        if (flush_i) begin
            st_d = StPass;
        end else if (handshake) begin
            st_d = hold_lf ? StCrSent : StPass;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q <= StPass;
        end else begin
            st_q <= st_d;
        end
    end
`else
    assign hold_lf   = 1'b0;
    assign tx_data_o = head;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Set wins over clear when both land in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign wr_ready_o = !full;
    assign tx_valid_o = !empty;
    assign count_o    = CNT_W'(wr_ptr_q - rd_ptr_q);
    assign empty_o    = empty;
    assign full_o     = full;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue (DEPTH=16); follows UART_TXQ_CRLF_EN if defined.
module tb_uart_tx_queue;

`ifdef UART_TXQ_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       flush = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_queue #(.DEPTH(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .flush_i    (flush),
        .ovf_clr_i  (ovf_clr),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_ready;
        logic       flush;
        logic       ovf_clr;
        logic [4:0] exp_count;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] emitted[$];
    logic [7:0] model[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string name, input logic [4:0] c, input logic v,
                               input logic [7:0] d, input logic f, input logic o);
        check({name, ".count"}, 32'(count), 32'(c));
        check({name, ".tx_valid"}, 32'(tx_valid), 32'(v));
        if (v) check({name, ".tx_data"}, 32'(tx_data), 32'(d));
        check({name, ".full"}, 32'(full), 32'(f));
        check({name, ".empty"}, 32'(empty), 32'(c == 5'd0));
        check({name, ".wr_ready"}, 32'(wr_ready), 32'(!f));
        check({name, ".overflow"}, 32'(overflow), 32'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    // An LF is expected as CR then LF when the expansion is built in.
    task automatic drain_one(input string name, input logic [7:0] exp);
        check({name, ".valid"}, 32'(tx_valid), 32'd1);
        if (CRLF && exp == 8'h0A) begin
            check({name, ".cr"}, 32'(tx_data), 32'h0D);
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
        end
        check({name, ".data"}, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 8'h42, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 8'h43, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Test 1: table-driven push / hold / drain
        for (int i = 0; i < 7; i++) begin
            wr_en    = vecs[i].wr_en;
            wr_data  = vecs[i].wr_data;
            tx_ready = vecs[i].tx_ready;
            flush    = vecs[i].flush;
            ovf_clr  = vecs[i].ovf_clr;
            if (tx_valid && tx_ready) emitted.push_back(tx_data);
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_valid,
                        vecs[i].exp_data, vecs[i].exp_full, vecs[i].exp_ovf);
        end
        wr_en = 1'b0;
        tx_ready = 1'b0;
        check("t1.emitted_n", 32'(emitted.size()), 32'd3);
        if (emitted.size() == 3) begin
            check("t1.emit0", 32'(emitted[0]), 32'h41);
            check("t1.emit1", 32'(emitted[1]), 32'h42);
            check("t1.emit2", 32'(emitted[2]), 32'h43);
        end

        // Test 2: fill past full, overflow set then cleared
        for (int i = 0; i < 17; i++) begin
            push(8'(i));
            if (i == 14) check_state("t2.p15", 5'd15, 1'b1, 8'h00, 1'b0, 1'b0);
            if (i == 15) check_state("t2.p16", 5'd16, 1'b1, 8'h00, 1'b1, 1'b0);
            if (i == 16) check_state("t2.p17", 5'd16, 1'b1, 8'h00, 1'b1, 1'b1);
        end
        for (int i = 0; i < 16; i++) drain_one("t2.drain", 8'(i));
        check_state("t2.drained", 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_state("t2.ovfclr", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Test 3a: simultaneous push/pop with 5 held
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        wr_en = 1'b1;
        wr_data = 8'h55;
        tx_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        tx_ready = 1'b0;
        check_state("t3.pushpop", 5'd5, 1'b1, 8'h51, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++) drain_one("t3.order", 8'h50 + 8'(i));
        check_state("t3.empty", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Test 3b: push+pop while full drops the push; then set beats clear
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
        wr_en = 1'b1;
        wr_data = 8'h70;
        tx_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        tx_ready = 1'b0;
        check_state("t3.fullpp", 5'd15, 1'b1, 8'h61, 1'b0, 1'b1);
        push(8'h71);
        check_state("t3.refull", 5'd16, 1'b1, 8'h61, 1'b1, 1'b1);
        wr_en = 1'b1;
        wr_data = 8'h72;
        ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        check_state("t3.setwins", 5'd16, 1'b1, 8'h61, 1'b1, 1'b1);
        for (int i = 1; i < 16; i++) drain_one("t3.fdrain", 8'h60 + 8'(i));
        drain_one("t3.last", 8'h71);
        check_state("t3.empty2", 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Test 4: continuous drain/refill across pointer wrap
        for (int i = 0; i < 16; i++) begin
            push(8'h80 + 8'(i));
            model.push_back(8'h80 + 8'(i));
        end
        drain_one("t4.first", model.pop_front());
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h90 + 8'(i);
            tx_ready = 1'b1;
            model.push_back(wr_data);
            check("t4.data", 32'(tx_data), 32'(model.pop_front()));
            tick();
            check("t4.count", 32'(count), 32'd15);
            check("t4.nofull", 32'(full), 32'd0);
            check("t4.noempty", 32'(empty), 32'd0);
        end
        wr_en = 1'b0;
        tx_ready = 1'b0;
        while (model.size() > 0) drain_one("t4.tail", model.pop_front());
        check_state("t4.empty", 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Test 5: flush beats a same-cycle push, overflow untouched
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        check_state("t5.held", 5'd4, 1'b1, 8'h20, 1'b0, 1'b1);
        wr_en = 1'b1;
        wr_data = 8'h24;
        flush = 1'b1;
        tick();
        wr_en = 1'b0;
        flush = 1'b0;
        check_state("t5.flush", 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check_state("t5.after", 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // Test 5b: asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
        check_state("t5.pre_rst", 5'd3, 1'b1, 8'h30, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_state("t5.async_rst", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        push(8'h33);
        check_state("t5.post_rst", 5'd1, 1'b1, 8'h33, 1'b0, 1'b0);
        drain_one("t5.drain", 8'h33);

        // Test 6: LF handling
        push(8'h48);
        push(8'h0A);
        check("t6.count2", 32'(count), 32'd2);
        tx_ready = 1'b1;
        check("t6.b0", 32'(tx_data), 32'h48);
        tick();
        check("t6.count1", 32'(count), 32'd1);
        if (CRLF) begin
            check("t6.cr", 32'(tx_data), 32'h0D);
            tick();
            check("t6.count1b", 32'(count), 32'd1);
        end
        check("t6.lf", 32'(tx_data), 32'h0A);
        tick();
        tx_ready = 1'b0;
        check("t6.count0", 32'(count), 32'd0);
        check("t6.novalid", 32'(tx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
